// File: rtl/punc_mem_arbiter_pkg.sv
// Shared definitions for the PUnC memory-port arbiter.
// Holds the arbiter state encodings, the requester index constants and
// the default bus widths used by the interface and the top.
package punc_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_LOCK_MAX = 4;

  // Requester indices; also the encoding of last_owner / rd_owner.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/punc_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
//   master : requesters + memory model (drives req/lock/we/addr/wdata, mem_rdata)
//   slave  : the arbiter (drives gnt, rvalid, rdata, mem_addr/we/wdata)
interface punc_mem_arbiter_if
  import punc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              req0,   req1;
  logic              lock0,  lock1;
  logic              we0,    we1;
  logic [ADDR_W-1:0] addr0,  addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0,   gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/punc_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port between the
// core (requester 0) and the debug/loader port (requester 1), with a bounded
// lock so multi-access sequences are not interleaved.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - punc_mem_arbiter_if.slave: requests/grants, tagged read return,
//          memory address/write-enable/write-data and memory read data
module punc_mem_arbiter
  import punc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                clk,
  input  logic                rst,
  punc_mem_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);

  arb_state_e       state;
  logic             last_owner;
  logic [CNT_W-1:0] lock_cnt;
  logic             rd_pending;
  logic             rd_owner;

  logic             gnt0, gnt1;
  logic [CNT_W-1:0] run_cnt;
  logic             rvalid0, rvalid1;

  // Grant decode; a lock whose owner stops requesting falls through to RR.
  // Nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state == LOCK0 && bus.req0) begin
        gnt0 = 1'b1;
      end else if (state == LOCK1 && bus.req1) begin
        gnt1 = 1'b1;
      end else if (bus.req0 && bus.req1) begin
        if (last_owner == REQ_DBG) gnt0 = 1'b1;
        else                       gnt1 = 1'b1;
      end else if (bus.req0) begin
        gnt0 = 1'b1;
      end else if (bus.req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Locked grants counted so far for the current owner (0 on a fresh grant).
  always_comb begin
    run_cnt = CNT_W'(0);
    if ((state == LOCK0 && gnt0) || (state == LOCK1 && gnt1)) run_cnt = lock_cnt;
  end

  // Memory port mux: idle values whenever nothing is granted.
  always_comb begin
    bus.mem_addr  = ADDR_W'(0);
    bus.mem_we    = 1'b0;
    bus.mem_wdata = DATA_W'(0);
    if (gnt0) begin
      bus.mem_addr  = bus.addr0;
      bus.mem_we    = bus.we0;
      bus.mem_wdata = bus.wdata0;
    end else if (gnt1) begin
      bus.mem_addr  = bus.addr1;
      bus.mem_we    = bus.we1;
      bus.mem_wdata = bus.wdata1;
    end
  end

  // Arbiter FSM, lock counter and read-tag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      last_owner <= REQ_DBG;
      lock_cnt   <= CNT_W'(0);
      rd_pending <= 1'b0;
      rd_owner   <= REQ_CORE;
    end else begin
      rd_pending <= (gnt0 && !bus.we0) || (gnt1 && !bus.we1);
      rd_owner   <= gnt1 ? REQ_DBG : REQ_CORE;
      if (gnt0) begin
        last_owner <= REQ_CORE;
        if (bus.lock0 && (int'(run_cnt) + 1 < int'(LOCK_MAX))) begin
          state    <= LOCK0;
          lock_cnt <= run_cnt + CNT_W'(1);
        end else begin
          state    <= ARB;
          lock_cnt <= CNT_W'(0);
        end
      end else if (gnt1) begin
        last_owner <= REQ_DBG;
        if (bus.lock1 && (int'(run_cnt) + 1 < int'(LOCK_MAX))) begin
          state    <= LOCK1;
          lock_cnt <= run_cnt + CNT_W'(1);
        end else begin
          state    <= ARB;
          lock_cnt <= CNT_W'(0);
        end
      end else begin
        state    <= ARB;
        lock_cnt <= CNT_W'(0);
      end
    end
  end

  // Read return; an in-flight read is dropped when reset is asserted.
  assign rvalid0 = rd_pending && (rd_owner == REQ_CORE) && !rst;
  assign rvalid1 = rd_pending && (rd_owner == REQ_DBG)  && !rst;

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0;
  assign bus.rvalid1 = rvalid1;
  assign bus.rdata0  = rvalid0 ? bus.mem_rdata : DATA_W'(0);
  assign bus.rdata1  = rvalid1 ? bus.mem_rdata : DATA_W'(0);

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed self-checking bench for punc_mem_arbiter with a small
// synchronous-read memory model. Inputs change on the falling edge and
// outputs are sampled 1ns later, away from the rising edge.
module tb_punc_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] mem [0:255];

  punc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory, indexed by the low address byte.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic l0, input logic w0,
                     input logic [15:0] a0, input logic [15:0] d0,
                     input logic r1, input logic l1, input logic w1,
                     input logic [15:0] a1, input logic [15:0] d1);
    bus.req0 = r0; bus.lock0 = l0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.lock1 = l1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  // Advance to the next falling edge, then let inputs settle.
  task automatic next();
    @(negedge clk);
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    check({tag, ".gnt0"}, 32'(bus.gnt0), 32'(g0));
    check({tag, ".gnt1"}, 32'(bus.gnt1), 32'(g1));
  endtask

  task automatic chk_rv(input string tag, input logic v0, input logic [15:0] d0,
                        input logic v1, input logic [15:0] d1);
    check({tag, ".rvalid0"}, 32'(bus.rvalid0), 32'(v0));
    check({tag, ".rvalid1"}, 32'(bus.rvalid1), 32'(v1));
    if (v0) check({tag, ".rdata0"}, 32'(bus.rdata0), 32'(d0));
    if (v1) check({tag, ".rdata1"}, 32'(bus.rdata1), 32'(d1));
  endtask

  task automatic chk_mem(input string tag, input logic [15:0] a, input logic w, input logic [15:0] d);
    check({tag, ".mem_addr"},  32'(bus.mem_addr),  32'(a));
    check({tag, ".mem_we"},    32'(bus.mem_we),    32'(w));
    check({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(d));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h1111;
    mem[8'h02] = 16'h2222;
    rst = 1'b1;
    idle();
    bus.mem_rdata = 16'h0;

    // Reset state
    repeat (2) next();
    #1;
    chk_gnt("rst", 0, 0);
    chk_rv("rst", 0, 16'h0, 0, 16'h0);
    chk_mem("rst", 16'h0, 0, 16'h0);
    check("rst.rdata0", 32'(bus.rdata0), 32'h0);
    rst = 1'b0;

    // Single core read of 0x3000
    next(); drv(1, 0, 0, 16'h3000, 16'h0, 0, 0, 0, 16'h0, 16'h0); #1;
    chk_gnt("c1", 1, 0); chk_mem("c1", 16'h3000, 0, 16'h0);
    check("c1.rvalid0", 32'(bus.rvalid0), 32'h0);
    next(); idle(); #1;
    chk_gnt("c2", 0, 0); chk_rv("c2", 1, 16'h1234, 0, 16'h0);
    chk_mem("c2", 16'h0, 0, 16'h0);

    // Debug read makes debug the last owner
    next(); drv(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0002, 16'h0); #1;
    chk_gnt("c3", 0, 1); chk_mem("c3", 16'h0002, 0, 16'h0);

    // Both requesting: grants alternate 0,1,0,1 with tagged returns
    next(); drv(1, 0, 0, 16'h3001, 16'h0, 1, 0, 0, 16'h0002, 16'h0); #1;
    chk_gnt("c4", 1, 0); chk_rv("c4", 0, 16'h0, 1, 16'h2222);
    next(); #1;
    chk_gnt("c5", 0, 1); chk_rv("c5", 1, 16'h1111, 0, 16'h0);
    next(); #1;
    chk_gnt("c6", 1, 0); chk_rv("c6", 0, 16'h0, 1, 16'h2222);
    next(); #1;
    chk_gnt("c7", 0, 1); chk_rv("c7", 1, 16'h1111, 0, 16'h0);
    next(); idle(); #1;
    chk_gnt("c8", 0, 0); chk_rv("c8", 0, 16'h0, 1, 16'h2222);

    // Debug write 0xBEEF to 0x0010, then core read back
    next(); drv(0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h0010, 16'hBEEF); #1;
    chk_gnt("c9", 0, 1); chk_mem("c9", 16'h0010, 1, 16'hBEEF);
    chk_rv("c9", 0, 16'h0, 0, 16'h0);
    next(); drv(1, 0, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0); #1;
    chk_gnt("c10", 1, 0); chk_mem("c10", 16'h0010, 0, 16'h0);
    chk_rv("c10", 0, 16'h0, 0, 16'h0);
    next(); idle(); #1;
    chk_rv("c11", 1, 16'hBEEF, 0, 16'h0);
    check("c11.mem_we", 32'(bus.mem_we), 32'h0);

    // Debug access so the core wins the next tie
    next(); drv(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0002, 16'h0); #1;
    chk_gnt("c12", 0, 1);

    // Core locked with debug always requesting: 4 core grants, then debug
    next(); drv(1, 1, 0, 16'h3001, 16'h0, 1, 0, 0, 16'h0002, 16'h0); #1;
    chk_gnt("lk1", 1, 0);
    next(); #1; chk_gnt("lk2", 1, 0);
    next(); #1; chk_gnt("lk3", 1, 0);
    next(); #1; chk_gnt("lk4", 1, 0);
    next(); #1; chk_gnt("lk5", 0, 1); chk_rv("lk5", 1, 16'h1111, 0, 16'h0);

    // Lock drop: core locks, then releases req while debug requests
    next(); drv(1, 1, 0, 16'h3001, 16'h0, 1, 0, 0, 16'h0002, 16'h0); #1;
    chk_gnt("dr1", 1, 0);
    next(); drv(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0002, 16'h0); #1;
    chk_gnt("dr2", 0, 1); chk_mem("dr2", 16'h0002, 0, 16'h0);
    // Back in ARB with debug as last owner: core wins the tie
    next(); drv(1, 0, 0, 16'h3001, 16'h0, 1, 0, 0, 16'h0002, 16'h0); #1;
    chk_gnt("dr3", 1, 0);
    next(); idle(); #1;
    chk_rv("dr4", 1, 16'h1111, 0, 16'h0);

    // Core read, then reset in the following cycle
    next(); drv(1, 0, 0, 16'h3000, 16'h0, 0, 0, 0, 16'h0, 16'h0); #1;
    chk_gnt("rr1", 1, 0);
    next(); rst = 1'b1;
    drv(1, 0, 0, 16'h3000, 16'h0, 1, 0, 0, 16'h0002, 16'h0); #1;
    chk_gnt("rr2", 0, 0); chk_rv("rr2", 0, 16'h0, 0, 16'h0);
    chk_mem("rr2", 16'h0, 0, 16'h0);
    check("rr2.rdata0", 32'(bus.rdata0), 32'h0);
    next(); rst = 1'b0; #1;
    chk_gnt("rr3", 1, 0); chk_rv("rr3", 0, 16'h0, 0, 16'h0);
    next(); idle(); #1;
    chk_rv("rr4", 1, 16'h1234, 0, 16'h0);

    next();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/punc_mem_arbiter.md
Name: punc_mem_arbiter

Overview:
- Shares the single PUnC memory port between two requesters.
  - Requester 0 is the core's fetch/load/store path.
  - Requester 1 is the debug/program-loader port.
- Round-robin arbitration with an optional bounded lock, so multi-access sequences (e.g. indirect LDI/STI) are not interleaved.
- Drives a synchronous-read memory. Read data returns one cycle after grant, tagged to the requester that issued it.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- LOCK_MAX, 4, max consecutive locked grants before forced release (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0/req1  in  1  access request
- lock0/lock1  in  1  keep ownership after this access
- we0/we1  in  1  1=write, 0=read
- addr0/addr1  in  ADDR_W  access address
- wdata0/wdata1  in  DATA_W  write data
- gnt0/gnt1  out  1  access accepted this cycle (combinational)
- rvalid0/rvalid1  out  1  read data valid (registered)
- rdata0/rdata1  out  DATA_W  read data, valid when rvalid set
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_addr

Interface decision: one clock, clk; reset rst is synchronous, active-high.

Behaviour:
- Reset values:
  - state=ARB, last_owner=1 (requester 0 wins the first tie), lock_cnt=0.
  - rvalid0/1=0, gnt0/1=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, rdata0/1=0.
- States: ARB, LOCK0, LOCK1.
- Grant, combinational, at most one gnt per cycle:
  - ARB: single requester is granted. Both requesting: grant the one != last_owner.
  - LOCKn: requester n is granted if reqn=1. The other is never granted.
  - LOCKn with reqn=0: lock is released in the same cycle and arbitration proceeds as in ARB.
- Memory side:
  - While granted: mem_addr/mem_we/mem_wdata follow the granted requester's inputs.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - If a grant with we=0 occurs in cycle t, rvalidn=1 in cycle t+1 for that requester only, and rdatan=mem_rdata.
  - rvalid pulses for exactly one cycle per read. A write produces no rvalid.
- Back-to-back reads to the same requester give consecutive rvalid cycles.
- On every grant, last_owner is set to the granted index.
- Lock sequencing, on a grant to n:
  - lockn=1 and lock_cnt+1 < LOCK_MAX: next state LOCKn, lock_cnt increments.
  - Otherwise: next state ARB, lock_cnt=0.
  - Forced release: after LOCK_MAX consecutive locked grants the next cycle is ARB. The other requester wins if it is requesting, by round-robin, since last_owner=n.
- Lock held but no request: state stays LOCKn only while reqn=1. If reqn drops, go to ARB and clear lock_cnt.
- Reset mid-operation: an outstanding read is discarded (no rvalid after reset) and any lock is cleared.
- A requester must hold req/addr/we/wdata stable until gnt. Address bits are passed through unmodified, with no wrap logic.

Decomposition:
- Shared package/defines: state encodings ARB/LOCK0/LOCK1 and requester index constants REQ_CORE=0, REQ_DBG=1, alongside the existing control defines.
- No sub-module. A single FSM with a lock counter and a read-tag register (rd_pending, rd_owner) is sufficient.

Test Plan:
- Reset, then req0 read addr=0x3000 with mem holding 0x1234 → gnt0=1 same cycle, rvalid0=1 and rdata0=0x1234 next cycle, rvalid1 stays 0.
- req0 and req1 both reads every cycle for 4 cycles → grants alternate 0,1,0,1. rvalid follows one cycle later with correct owner tags.
- req1 write addr=0x0010 data=0xBEEF, then req0 read 0x0010 → mem_we=1 only in the write cycle, rdata0=0xBEEF, no rvalid1.
- req0 held with lock0=1, req1 constantly requesting, LOCK_MAX=4 → gnt0 for 4 cycles, then gnt1 on cycle 5.
- In LOCK0, req0 drops while req1 requests → gnt1 in that same cycle, state ARB.
- Issue req0 read, then assert rst in the next cycle → rvalid0 stays 0, all outputs return to reset values, first post-reset tie grants requester 0.
